// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared encodings and helpers for the DataMemory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;

  localparam int P_CPU = 0;
  localparam int P_LDR = 1;

  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  typedef enum logic {
    ST_IDLE   = IDLE,
    ST_LOCKED = LOCKED
  } arb_state_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & MISALIGN_MASK) != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin picker with optional single-port mask.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       mask_en,
  input  logic       mask_sel,
  output logic [1:0] gnt
);

  logic [1:0] req_m;

  always_comb begin
    req_m = req;
    if (mask_en) begin
      req_m = mask_sel ? (req & 2'b10) : (req & 2'b01);
    end
    // prio selects the favoured port when both contend
    if (req_m == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end else begin
      gnt = req_m;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port round-robin arbiter/sequencer for DataMemory with lock.
// Revision : 1.0 - initial release
// ============================================================================
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              lock_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_WARN = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              lock_err_q, lock_err_d;

  logic [1:0]        req_v, req_eff, gnt_v;
  logic              locked, timeout, any_gnt, win;
  logic              sel_we, sel_lock, mis, owner_req, owner_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, resp_data;

  assign req_v   = {req1, req0};
  assign locked  = (state_q == ST_LOCKED);
  assign timeout = locked && (cnt_q == CNT_MAX);
  // forced release wins over any same-cycle owner request
  assign req_eff = timeout ? 2'b00 : req_v;

  rr_arb2 u_rr_arb2 (
    .req      (req_eff),
    .prio     (prio_q),
    .mask_en  (locked),
    .mask_sel (owner_q),
    .gnt      (gnt_v)
  );

  assign gnt0    = gnt_v[P_CPU];
  assign gnt1    = gnt_v[P_LDR];
  assign any_gnt = |gnt_v;
  assign win     = gnt_v[P_LDR];

  assign sel_we    = win ? we1    : we0;
  assign sel_lock  = win ? lock1  : lock0;
  assign sel_addr  = win ? addr1  : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;
  assign mis       = is_misaligned(sel_addr[1:0]);

  assign mem_addr  = any_gnt ? sel_addr  : '0;
  assign mem_wdata = any_gnt ? sel_wdata : '0;
  assign mem_write = any_gnt &&  sel_we && !mis;
  assign mem_read  = any_gnt && !sel_we && !mis;

  assign owner_req  = owner_q ? req1  : req0;
  assign owner_lock = owner_q ? lock1 : lock0;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    lock_err_d = 1'b0;
    if (any_gnt) begin
      prio_d = ~win;
    end
    case (state_q)
      ST_IDLE: begin
        if (any_gnt && sel_lock) begin
          state_d = ST_LOCKED;
          owner_d = win;
          cnt_d   = CNT_ONE;
        end
      end
      ST_LOCKED: begin
        if (timeout || (any_gnt && !sel_lock) || (!owner_req && !owner_lock)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          prio_d  = ~owner_q;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          // flag lands in the cycle the counter sits at its limit
          lock_err_d = (cnt_q == CNT_WARN);
        end
      end
    endcase
  end

  always_comb begin
    resp_data = (any_gnt && !sel_we && !mis) ? mem_rdata : '0;
    rvalid_d  = gnt_v;
    err_d     = gnt_v & {2{mis}};
    rdata0_d  = gnt_v[P_CPU] ? resp_data : rdata0_q;
    rdata1_d  = gnt_v[P_LDR] ? resp_data : rdata1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      rvalid_q   <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign rvalid0  = rvalid_q[P_CPU];
  assign rvalid1  = rvalid_q[P_LDR];
  assign err0     = err_q[P_CPU];
  assign err1     = err_q[P_LDR];
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign lock_err = lock_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed vectors plus randomized traffic for dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1, lock_err;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_write, mem_read;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .lock_err(lock_err), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_read(mem_read), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // DataMemory stand-in: 16 words, combinational read, write on rising edge
  logic [DW-1:0] dmem [16];
  assign mem_rdata = dmem[mem_addr[5:2]];
  initial begin
    for (int i = 0; i < 16; i++) dmem[i] = 32'h1000 + i;
    forever begin
      @(posedge clk);
      if (mem_write) dmem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [DW-1:0] ref_mem [16];
  bit            m_locked;
  int            m_owner, m_age, m_last;
  bit            e_rv [2];
  bit            e_er [2];
  bit            e_le;
  logic [DW-1:0] e_rd [2];

  function automatic logic rq(int p);                return p ? req1 : req0; endfunction
  function automatic logic wen(int p);               return p ? we1 : we0; endfunction
  function automatic logic lk(int p);                return p ? lock1 : lock0; endfunction
  function automatic logic [AW-1:0] ad(int p);       return p ? addr1 : addr0; endfunction
  function automatic logic [DW-1:0] wd(int p);       return p ? wdata1 : wdata0; endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_age = 0; m_last = 1; e_le = 0;
    for (int p = 0; p < 2; p++) begin e_rv[p] = 0; e_er[p] = 0; e_rd[p] = '0; end
  endtask

  function automatic int m_winner();
    if (m_locked) begin
      if (m_age >= LT) return -1;
      return rq(m_owner) ? m_owner : -1;
    end
    if (rq(0) && rq(1)) return 1 - m_last;
    if (rq(0)) return 0;
    if (rq(1)) return 1;
    return -1;
  endfunction

  task automatic model_check();
    int w; logic [AW-1:0] a; bit mis;
    w = m_winner();
    a = (w >= 0) ? ad(w) : '0;
    mis = (w >= 0) && (a[1:0] != 2'b00);
    chk("m_gnt0", gnt0, w == 0);
    chk("m_gnt1", gnt1, w == 1);
    chk("m_mem_addr", mem_addr, a);
    chk("m_mem_wdata", mem_wdata, (w >= 0) ? wd(w) : '0);
    chk("m_mem_write", mem_write, (w >= 0) && wen(w) && !mis);
    chk("m_mem_read", mem_read, (w >= 0) && !wen(w) && !mis);
    chk("m_rvalid0", rvalid0, e_rv[0]);
    chk("m_rvalid1", rvalid1, e_rv[1]);
    chk("m_err0", err0, e_er[0]);
    chk("m_err1", err1, e_er[1]);
    chk("m_rdata0", rdata0, e_rd[0]);
    chk("m_rdata1", rdata1, e_rd[1]);
    chk("m_lock_err", lock_err, e_le);
  endtask

  task automatic model_advance();
    int w; logic [AW-1:0] a; bit mis, wr;
    w = m_winner();
    e_le = 0;
    for (int p = 0; p < 2; p++) begin e_rv[p] = (w == p); e_er[p] = 0; end
    if (w >= 0) begin
      a = ad(w); mis = (a[1:0] != 2'b00); wr = wen(w);
      e_er[w] = mis;
      e_rd[w] = (!wr && !mis) ? ref_mem[a[5:2]] : '0;
      if (wr && !mis) ref_mem[a[5:2]] = wd(w);
      m_last = w;
    end
    if (!m_locked) begin
      if (w >= 0 && lk(w)) begin m_locked = 1; m_owner = w; m_age = 1; end
    end else if ((m_age >= LT) || (w == m_owner && !lk(m_owner)) || (!rq(m_owner) && !lk(m_owner))) begin
      m_locked = 0; m_last = m_owner;
    end else begin
      m_age++;
      if (m_age == LT) e_le = 1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r0, w0, l0; logic [31:0] a0, d0;
    logic r1, w1, l1; logic [31:0] a1, d1;
    logic g0, g1, mw, mr;
    logic v0, e0; logic [31:0] rd0;
    logic v1, e1; logic [31:0] rd1;
    logic le;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r0, w0, input logic [31:0] a0, d0, input logic l0,
                     input logic r1, w1, input logic [31:0] a1, d1, input logic l1,
                     input logic g0, g1, mw, mr,
                     input logic v0, e0, input logic [31:0] rd0,
                     input logic v1, e1, input logic [31:0] rd1, input logic le);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
    v.g0 = g0; v.g1 = g1; v.mw = mw; v.mr = mr;
    v.v0 = v0; v.e0 = e0; v.rd0 = rd0; v.v1 = v1; v.e1 = e1; v.rd1 = rd1; v.le = le;
    vecs.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v, input int i);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0; lock0 = v.l0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1; lock1 = v.l1;
    @(negedge clk);
    chk($sformatf("v%0d_gnt0", i), gnt0, v.g0);
    chk($sformatf("v%0d_gnt1", i), gnt1, v.g1);
    chk($sformatf("v%0d_mem_write", i), mem_write, v.mw);
    chk($sformatf("v%0d_mem_read", i), mem_read, v.mr);
    chk($sformatf("v%0d_mem_addr", i), mem_addr, v.g0 ? v.a0 : (v.g1 ? v.a1 : 32'd0));
    chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v.g0 ? v.d0 : (v.g1 ? v.d1 : 32'd0));
    chk($sformatf("v%0d_rvalid0", i), rvalid0, v.v0);
    chk($sformatf("v%0d_err0", i), err0, v.e0);
    chk($sformatf("v%0d_rdata0", i), rdata0, v.rd0);
    chk($sformatf("v%0d_rvalid1", i), rvalid1, v.v1);
    chk($sformatf("v%0d_err1", i), err1, v.e1);
    chk($sformatf("v%0d_rdata1", i), rdata1, v.rd1);
    chk($sformatf("v%0d_lock_err", i), lock_err, v.le);
    model_advance();
    @(posedge clk); #1;
  endtask

  task automatic set_port(input int p, input logic r, w, input logic [31:0] a, d, input logic l);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit pend [2];
    int w;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000 + i;
    rst = 1'b1;
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
    model_reset();

    // contention, both ports reading
    for (int c = 0; c < 4; c++)
      add(1,0,0,0,0, 1,0,4,0,0, c%2==0, c%2==1, 0, 1,
          c==1 || c==3, 0, (c==0) ? 32'h0 : 32'h1000, c==2, 0, (c>=2) ? 32'h1001 : 32'h0, 0);
    add(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,32'h1000, 1,0,32'h1001, 0);
    // write then read
    add(1,1,24,151,0, 0,0,0,0,0, 1,0,1,0, 0,0,32'h1000, 0,0,32'h1001, 0);
    add(1,0,24,0,0,   0,0,0,0,0, 1,0,0,1, 1,0,32'h0,    0,0,32'h1001, 0);
    add(0,0,0,0,0,    0,0,0,0,0, 0,0,0,0, 1,0,32'd151,  0,0,32'h1001, 0);
    // misaligned write, then read of the neighbouring word
    add(0,0,0,0,0, 1,1,6,32'hdead,0, 0,1,0,0, 0,0,32'd151, 0,0,32'h1001, 0);
    add(0,0,0,0,0, 1,0,4,0,0,        0,1,0,1, 0,0,32'd151, 1,1,32'h0,    0);
    add(0,0,0,0,0, 0,0,0,0,0,        0,0,0,0, 0,0,32'd151, 1,0,32'h1001, 0);
    // locked read-modify-write with port 1 waiting
    add(1,0,8,0,1,  1,0,12,0,0, 1,0,0,1, 0,0,32'd151,  0,0,32'h1001, 0);
    add(1,1,8,77,0, 1,0,12,0,0, 1,0,1,0, 1,0,32'h1002, 0,0,32'h1001, 0);
    add(0,0,0,0,0,  1,0,12,0,0, 0,1,0,1, 1,0,32'h0,    0,0,32'h1001, 0);
    add(0,0,0,0,0,  0,0,0,0,0,  0,0,0,0, 0,0,32'h0,    1,0,32'h1003, 0);
    // lock timeout: owner drops req but keeps lock asserted
    add(1,0,16,0,1, 0,0,0,0,0,  1,0,0,1, 0,0,32'h0,    0,0,32'h1003, 0);
    for (int k = 1; k <= 4; k++)
      add(0,0,0,0,1, 1,0,20,0,0, 0,0,0,0, k==1,0,32'h1004, 0,0,32'h1003, k==4);
    add(0,0,0,0,0,  1,0,20,0,0, 0,1,0,1, 0,0,32'h1004, 0,0,32'h1003, 0);
    add(0,0,0,0,0,  0,0,0,0,0,  0,0,0,0, 0,0,32'h1004, 1,0,32'h1005, 0);

    #2;
    chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);   chk("rst_rdata1", rdata1, 0);
    chk("rst_err", {err0, err1}, 0); chk("rst_lock_err", lock_err, 0);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_mem", {mem_write, mem_read, mem_addr, mem_wdata}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // asynchronous reset in the cycle after a read grant
    set_port(0, 1, 0, 0, 0, 0);
    set_port(1, 1, 0, 4, 0, 0);
    @(negedge clk); chk("mid_pre_gnt0", gnt0, 1);
    @(posedge clk); #1; chk("mid_pre_rvalid0", rvalid0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rvalid0", rvalid0, 0); chk("mid_rvalid1", rvalid1, 0);
    chk("mid_rdata0", rdata0, 0);   chk("mid_rdata1", rdata1, 0);
    chk("mid_err", {err0, err1}, 0); chk("mid_lock_err", lock_err, 0);
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0; model_reset();
    @(posedge clk); #1;
    set_port(0, 1, 0, 0, 0, 0);
    set_port(1, 1, 0, 4, 0, 0);
    @(negedge clk);
    chk("post_rst_gnt0", gnt0, 1); chk("post_rst_gnt1", gnt1, 0);
    model_check(); model_advance();
    @(posedge clk); #1;
    pend[0] = 0; pend[1] = 1;

    // randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 99) < 60) begin
            set_port(p, 1, $urandom_range(0, 1) == 1,
                     {26'd0, 4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 85) ? 2'b00 : 2'($urandom_range(1, 3))},
                     $urandom, $urandom_range(0, 99) < 25);
            pend[p] = 1;
          end else begin
            set_port(p, 0, 0, 0, 0, $urandom_range(0, 99) < 15);
          end
        end
      end
      @(negedge clk);
      w = m_winner();
      model_check();
      model_advance();
      if (w >= 0) pend[w] = 0;
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the word-addressed DataMemory. Port 0 is the CPU data path; port 1 is the loader/debug path.
- Grants one request per cycle with round-robin priority and drives the memory's address, write-data and read/write strobes.
- Returns read data or a write acknowledge one cycle later.
- Supports an optional lock for multi-word atomic sequences, with a lock timeout.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LOCK_TIMEOUT, 16, maximum consecutive cycles a lock may be held before forced release (≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request valid; held with its command until gnt
- we0 / we1  in  1  1=write, 0=read
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  DATA_W  write data
- lock0 / lock1  in  1  keep ownership after this grant
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  response pulse, one cycle after gnt
- rdata0 / rdata1  out  DATA_W  read data, valid with rvalid
- err0 / err1  out  1  response error, valid with rvalid
- lock_err  out  1  one-cycle pulse on forced lock release
- mem_addr  out  ADDR_W  to DataMemory address
- mem_write  out  1  to MemWrite
- mem_read  out  1  to MemRead
- mem_wdata  out  DATA_W  to WriteData
- mem_rdata  in  DATA_W  from DataMemory read data (combinational read)

Behaviour:
- Reset (asynchronous): state=IDLE; priority pointer favours port 0; lock counter=0. All registered outputs (rvalid*, rdata*, err*, lock_err) are 0. Combinational outputs evaluate to 0 while no request is pending.
- Arbitration in IDLE:
  - Only one requester active: it is granted.
  - Both active: the port not granted most recently wins.
  - The pointer updates on every grant.
- At most one gnt per cycle.
- Issue cycle:
  - mem_addr, mem_wdata, mem_write=we and mem_read=~we are driven combinationally from the winner.
  - The memory write commits at the rising edge ending that cycle.
  - mem_rdata is captured into rdata at that same edge.
- No grant: mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
- Response: rvalid of the granted port is high exactly one cycle after gnt.
  - Read: rdata = captured mem_rdata.
  - Write: rdata=0.
  - rdata holds its value until the next response on that port.
- Misalignment: addr[1:0]≠0 is still granted, but mem_write and mem_read stay 0. The response carries err=1 and rdata=0.
- Lock:
  - A grant with lock=1 moves the FSM to LOCKED, with owner = that port and counter=1.
  - In LOCKED only the owner can be granted. The counter increments each cycle and saturates.
  - Release to IDLE when either: (a) the owner is granted with lock=0 (that grant is honoured), or (b) owner req=0 and lock=0.
  - After release, the pointer favours the non-owner.
- Lock timeout: when the counter reaches LOCK_TIMEOUT without a release, the FSM forces IDLE and lock_err pulses for 1 cycle.
  - The owner is not granted in the timeout cycle.
  - The other port is granted next if requesting.
- Simultaneous events: in the timeout cycle, the forced release takes precedence over a same-cycle owner grant.
- Reset mid-transaction: a pending rvalid is dropped, and a memory write already committed remains in memory.

Decomposition:
- Shared package (dmem_arb_pkg):
  - state encoding constants IDLE=1'b0, LOCKED=1'b1
  - port index constants P_CPU=0, P_LDR=1
  - misalignment mask constant 2'b11
- One sub-module, rr_arb2: a 2-way round-robin picker.
  - Inputs: req[1:0], prio (1 bit), mask_en, mask_sel.
  - Outputs: one-hot gnt[1:0].
  - Pointer storage stays in dmem_arbiter.

Test Plan:
- Single write then read: req0 write addr=6*4=24, wdata=151 → gnt0 same cycle, mem_write=1, rvalid0 next cycle with err0=0. Then req0 read addr=24 → rdata0=151 one cycle after gnt0.
- Contention: req0 and req1 both reading (addr 0 and 4) held for 4 cycles → gnt pattern 0,1,0,1 and rvalid on the matching port the cycle after each grant.
- Misaligned access: req1 write addr=6 → gnt1=1, mem_write=0, rvalid1=1 with err1=1; a read of addr=4 afterwards returns its prior contents.
- Lock sequence: req0 read addr=8 with lock0=1, then write addr=8 with lock0=0, while req1 is held throughout → gnt1 stays 0 until the write is granted, then gnt1 in the next cycle.
- Lock timeout with LOCK_TIMEOUT=4: port 0 locks and then stops requesting with lock0=1 → lock_err pulses at cycle 4 after the lock grant, and gnt1 follows in the next cycle.
- Async reset asserted mid-operation, on the cycle after a read grant → rvalid*, rdata*, err* and lock_err are 0 immediately, the FSM is in IDLE, and the first grant after reset goes to port 0 when both ports request.
